vga_layer_compositor: RTL
=========================

// Module: vga_layer_compositor
//
// PURPOSE
//   N-layer pixel compositor for the VGA path. It replaces the fixed 2:1 memory/generator select.
//   Each pixel tick it picks the highest-priority enabled, non-transparent layer, or falls back to
//   a background colour. Layer enables are retimed to frame boundaries so layers never tear.
//   The output is a 2-stage registered pixel pipeline with a delayed bright flag. It also keeps a
//   per-frame count of pixels that showed the background.
//   It sits between the layer sources (bitmap memory, pattern generators) and the VGA output pins.
//
// PARAMETERS
//   PIX_W   8   bits per pixel (RGB332 at default)
//   LAYERS  4   number of input layers; index LAYERS-1 = highest priority
//   CNT_W   20  width of background-pixel counters
//
// PORTS
//   clk            in   1              system clock
//   reset          in   1              synchronous, active-high reset
//   pix_en         in   1              pixel tick; the pipeline advances only when 1
//   bright         in   1              active-video flag aligned with layer_rgb
//   frame_start    in   1              1-cycle pulse at start of vertical blank
//   layer_rgb      in   LAYERS*PIX_W   packed pixels; layer i = [i*PIX_W +: PIX_W]
//   layer_en_req   in   LAYERS         requested layer enables, applied at frame_start
//   key_en         in   1              1 = key_color is transparent
//   key_color      in   PIX_W          transparency key
//   bg_color       in   PIX_W          colour shown when no layer wins
//   rgb_out        out  PIX_W          composited pixel, registered
//   bright_out     out  1              bright delayed by 2 pix_en ticks
//   hit_layer      out  clog2(LAYERS)  index of the winning layer (0 when hit_none)
//   hit_none       out  1              1 = background shown
//   layer_en_act   out  LAYERS         enables currently in effect
//   bg_count_last  out  CNT_W          background pixel count of the previous frame
//
// BEHAVIOUR
//   Reset values:
//   - rgb_out=0, bright_out=0, hit_layer=0, hit_none=0.
//   - layer_en_act={LAYERS{1}}, bg_count_last=0.
//   - Internal bg_count=0 and both pipeline stages are cleared.
//   - Reset mid-frame discards in-flight pixels and the partial count.
//   Stage 1, on clk when pix_en=1:
//   - Register layer_rgb and bright.
//   - When pix_en=0, every pipeline register holds.
//   Stage 2, on clk when pix_en=1:
//   - Scan i = LAYERS-1 down to 0. Layer i is eligible when layer_en_act[i]=1 and
//     !(key_en && pixel_i==key_color).
//   - The first eligible layer wins: rgb_out=pixel_i, hit_layer=i, hit_none=0.
//   - No eligible layer: rgb_out=bg_color, hit_layer=0, hit_none=1.
//   - Stage-1 bright=0: rgb_out=0 (forced black), hit_none=0, hit_layer=0.
//   - bright_out = stage-1 bright.
//   - Latency: the input sampled at pix_en tick k appears on the outputs after tick k+1.
//     That is 2 ticks; in cycles, 2 clocks when pix_en is held high.
//   Enable retiming:
//   - layer_en_act <= layer_en_req on any clk with frame_start=1, regardless of pix_en.
//   - layer_en_req is ignored at all other times.
//   - Stage 2 evaluates against the value of layer_en_act before the edge, so the new
//     enables are seen from the next edge on.
//   Background counter:
//   - bg_count increments on each stage-2 update that yields bright=1 and hit_none=1.
//   - It saturates at 2^CNT_W-1 and never wraps.
//   - frame_start: bg_count_last <= bg_count, and bg_count <= 0.
//   - Same-cycle increment with frame_start: the increment is dropped; frame_start wins.
//   bg_color, key_color and key_en are used live at stage 2; they are not retimed.
//
// TESTING
//   (LAYERS=4, PIX_W=8.)
//   1. Reset: assert reset 2 clks -> rgb_out=00, bright_out=0, layer_en_act=4'hF,
//      bg_count_last=0.
//   2. Priority: L3=E0, L2=1C, L1=03, L0=FF; bright=1; pix_en always 1; key_en=0
//      -> 2 clks later rgb_out=E0, hit_layer=3. Then set L3=key=E0, key_en=1
//      -> rgb_out=1C, hit_layer=2.
//   3. Background: all layers=E0=key, key_en=1, bg_color=49 -> rgb_out=49, hit_none=1.
//      Drop bright to 0 -> rgb_out=00 two ticks later, bright_out=0.
//   4. Retiming: layer_en_req=4'b0001 with no frame_start -> layer_en_act stays F,
//      rgb_out=E0. Pulse frame_start -> layer_en_act=1, then rgb_out=FF, hit_layer=0.
//   5. Pixel tick: pix_en every 2nd clk -> outputs change only on edges with pix_en=1.
//      Latency = 2 ticks (4 clks). With pix_en=0, stale inputs do not propagate.
//   6. Counter: 10 active bg pixels, then frame_start -> bg_count_last=10.
//      Next frame 0 bg pixels -> 0. With CNT_W=3 and 12 bg pixels -> 7 (saturated).
//      frame_start on the same cycle as a bg increment -> increment dropped.

Source files
------------

// File: rtl/vga_layer_compositor.sv
// N-layer priority pixel compositor with colour-key transparency, frame-retimed layer enables,
// a 2-stage pixel pipeline and a per-frame background-pixel counter.
module vga_layer_compositor #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LAYERS = 4,
    parameter int unsigned CNT_W  = 20,
    localparam int unsigned HIT_W = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_pix_en,
    input  logic                      i_bright,
    input  logic                      i_frame_start,
    input  logic [LAYERS*PIX_W-1:0]   i_layer_rgb,
    input  logic [LAYERS-1:0]         i_layer_en_req,
    input  logic                      i_key_en,
    input  logic [PIX_W-1:0]          i_key_color,
    input  logic [PIX_W-1:0]          i_bg_color,
    output logic [PIX_W-1:0]          o_rgb_out,
    output logic                      o_bright_out,
    output logic [HIT_W-1:0]          o_hit_layer,
    output logic                      o_hit_none,
    output logic [LAYERS-1:0]         o_layer_en_act,
    output logic [CNT_W-1:0]          o_bg_count_last
);

    logic [LAYERS*PIX_W-1:0] r_s1_rgb;
    logic                    r_s1_bright;
    logic [LAYERS-1:0]       r_layer_en_act;
    logic [CNT_W-1:0]        r_bg_count;
    logic [CNT_W-1:0]        r_bg_count_last;
    logic [PIX_W-1:0]        r_rgb_out;
    logic                    r_bright_out;
    logic [HIT_W-1:0]        r_hit_layer;
    logic                    r_hit_none;

    logic                    w_win;
    logic [HIT_W-1:0]        w_win_idx;
    logic [PIX_W-1:0]        w_win_pix;
    logic                    w_bg_inc;

    // Ascending scan: a later (higher-index) eligible layer overrides, so the top one wins.
    always_comb begin
        w_win     = 1'b0;
        w_win_idx = '0;
        w_win_pix = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (r_layer_en_act[i] &&
                !(i_key_en && (r_s1_rgb[i*PIX_W +: PIX_W] == i_key_color))) begin
                w_win     = 1'b1;
                w_win_idx = HIT_W'(i);
                w_win_pix = r_s1_rgb[i*PIX_W +: PIX_W];
            end
        end
    end

    assign w_bg_inc = i_pix_en && r_s1_bright && !w_win;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_rgb        <= '0;
            r_s1_bright     <= 1'b0;
            r_layer_en_act  <= '1;
            r_bg_count      <= '0;
            r_bg_count_last <= '0;
            r_rgb_out       <= '0;
            r_bright_out    <= 1'b0;
            r_hit_layer     <= '0;
            r_hit_none      <= 1'b0;
        end else begin
            if (i_pix_en) begin
                r_s1_rgb     <= i_layer_rgb;
                r_s1_bright  <= i_bright;
                r_bright_out <= r_s1_bright;
                if (!r_s1_bright) begin
                    r_rgb_out   <= '0;
                    r_hit_layer <= '0;
                    r_hit_none  <= 1'b0;
                end else if (w_win) begin
                    r_rgb_out   <= w_win_pix;
                    r_hit_layer <= w_win_idx;
                    r_hit_none  <= 1'b0;
                end else begin
                    r_rgb_out   <= i_bg_color;
                    r_hit_layer <= '0;
                    r_hit_none  <= 1'b1;
                end
            end

            // frame_start takes priority over a same-cycle background increment.
            if (i_frame_start) begin
                r_layer_en_act  <= i_layer_en_req;
                r_bg_count_last <= r_bg_count;
                r_bg_count      <= '0;
            end else if (w_bg_inc && (r_bg_count != {CNT_W{1'b1}})) begin
                r_bg_count <= r_bg_count + 1'b1;
            end
        end
    end

    assign o_rgb_out       = r_rgb_out;
    assign o_bright_out    = r_bright_out;
    assign o_hit_layer     = r_hit_layer;
    assign o_hit_none      = r_hit_none;
    assign o_layer_en_act  = r_layer_en_act;
    assign o_bg_count_last = r_bg_count_last;

endmodule
